// File: rtl/udp_ip_tx_framer.sv
// udp_ip_tx_framer: builds an IPv4+UDP packet stream from the udp_ip config registers.
// Each accepted length request emits a 28-byte header (IP checksum computed, UDP checksum
// zero) followed by that many payload bytes, then bumps the IPv4 identification counter.
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   cfg_src_ip, cfg_dst_ip  IPv4 source / destination address
//   cfg_ports               [31:16] UDP source port, [15:0] UDP destination port
//   cfg_ttl                 IPv4 time-to-live
//   len_valid/len_ready     payload length request handshake, len_data = byte count
//   s_t*                    8-bit payload stream in
//   m_t*                    8-bit packet stream out
//   err_clr                 clears both sticky error flags
//   err_len_cfg             sticky: a length of 0 or above LEN_MAX was rejected
//   err_len_mis             sticky: payload s_tlast did not land on byte len
module udp_ip_tx_framer #(
   parameter int unsigned LEN_MAX = 1472,
   parameter logic [15:0] ID_INIT = 16'h0000
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [31:0] cfg_src_ip,
   input  logic [31:0] cfg_dst_ip,
   input  logic [31:0] cfg_ports,
   input  logic [7:0]  cfg_ttl,
   input  logic        len_valid,
   output logic        len_ready,
   input  logic [15:0] len_data,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   input  logic        err_clr,
   output logic        err_len_cfg,
   output logic        err_len_mis
);

   typedef enum logic [2:0] {StIdle, StSum, StFold, StHdr, StPay, StPad, StDrop} state_e;

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [31:0] ports_q, ports_d;
   logic [7:0]  ttl_q, ttl_d;
   logic [15:0] id_q, id_d;
   logic [31:0] sum_q, sum_d;
   logic [15:0] csum_q, csum_d;
   logic [4:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_cfg_q, err_cfg_d;
   logic        err_mis_q, err_mis_d;
   logic        set_cfg, set_mis;

   logic [15:0]  totlen, udplen;
   logic [223:0] hdr_vec;
   logic [7:0]   hdr_base;
   logic [16:0]  fold1;
   logic [15:0]  fold2;
   logic         len_ok;
   logic         last_byte;

   assign totlen   = len_q + 16'd28;
   assign udplen   = len_q + 16'd8;
   assign hdr_vec  = {16'h4500, totlen, id_q, 16'h4000, ttl_q, 8'h11, csum_q,
                      src_q, dst_q, ports_q, udplen, 16'h0000};
   // Byte 0 sits in the top 8 bits of hdr_vec.
   assign hdr_base = 8'd216 - {idx_q, 3'b000};

   // Two end-around-carry folds are enough: the ten-word sum stays below 2^20.
   assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
   assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

   assign len_ok    = (len_data != 16'd0) && (32'(len_data) <= LEN_MAX);
   assign last_byte = (cnt_q + 16'd1) == len_q;

   assign err_len_cfg = err_cfg_q;
   assign err_len_mis = err_mis_q;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      src_d     = src_q;
      dst_d     = dst_q;
      ports_d   = ports_q;
      ttl_d     = ttl_q;
      id_d      = id_q;
      sum_d     = sum_q;
      csum_d    = csum_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      set_cfg   = 1'b0;
      set_mis   = 1'b0;
      len_ready = 1'b0;
      s_tready  = 1'b0;
      m_tvalid  = 1'b0;
      m_tdata   = 8'h00;
      m_tlast   = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Gated so every output reads 0 while reset is held.
            len_ready = !ARESET;
            if (len_valid) begin
               if (len_ok) begin
                  len_d   = len_data;
                  src_d   = cfg_src_ip;
                  dst_d   = cfg_dst_ip;
                  ports_d = cfg_ports;
                  ttl_d   = cfg_ttl;
                  idx_d   = 5'd0;
                  cnt_d   = 16'd0;
                  state_d = StSum;
               end else begin
                  set_cfg = 1'b1;
               end
            end
         end
         StSum: begin
            sum_d = 32'h0000_4500 + {16'd0, totlen} + {16'd0, id_q} + 32'h0000_4000
                  + {16'd0, ttl_q, 8'h11} + {16'd0, src_q[31:16]} + {16'd0, src_q[15:0]}
                  + {16'd0, dst_q[31:16]} + {16'd0, dst_q[15:0]};
            state_d = StFold;
         end
         StFold: begin
            csum_d  = ~fold2;
            state_d = StHdr;
         end
         StHdr: begin
            m_tvalid = 1'b1;
            m_tdata  = hdr_vec[hdr_base +: 8];
            if (m_tready) begin
               if (idx_q == 5'd27) state_d = StPay;
               else                idx_d   = idx_q + 5'd1;
            end
         end
         StPay: begin
            m_tdata  = s_tdata;
            m_tvalid = s_tvalid;
            m_tlast  = last_byte;
            s_tready = m_tready;
            if (s_tvalid && m_tready) begin
               cnt_d = cnt_q + 16'd1;
               if (last_byte) begin
                  id_d = id_q + 16'd1;
                  if (s_tlast) begin
                     state_d = StIdle;
                  end else begin
                     set_mis = 1'b1;
                     state_d = StDrop;
                  end
               end else if (s_tlast) begin
                  set_mis = 1'b1;
                  state_d = StPad;
               end
            end
         end
         StPad: begin
            m_tvalid = 1'b1;
            m_tlast  = last_byte;
            if (m_tready) begin
               cnt_d = cnt_q + 16'd1;
               if (last_byte) begin
                  id_d    = id_q + 16'd1;
                  state_d = StIdle;
               end
            end
         end
         StDrop: begin
            s_tready = 1'b1;
            if (s_tvalid && s_tlast) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A new error outranks a simultaneous clear.
      err_cfg_d = (err_cfg_q && !err_clr) || set_cfg;
      err_mis_d = (err_mis_q && !err_clr) || set_mis;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= StIdle;
         len_q     <= 16'd0;
         src_q     <= 32'd0;
         dst_q     <= 32'd0;
         ports_q   <= 32'd0;
         ttl_q     <= 8'd0;
         id_q      <= ID_INIT;
         sum_q     <= 32'd0;
         csum_q    <= 16'd0;
         idx_q     <= 5'd0;
         cnt_q     <= 16'd0;
         err_cfg_q <= 1'b0;
         err_mis_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         ports_q   <= ports_d;
         ttl_q     <= ttl_d;
         id_q      <= id_d;
         sum_q     <= sum_d;
         csum_q    <= csum_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         err_cfg_q <= err_cfg_d;
         err_mis_q <= err_mis_d;
      end
   end

endmodule
